// File: rtl/eth_rx_filter.sv
// EtherType receive filter: holds the first four beats of each frame, decides
// pass/drop from the EtherType, then replays and streams or discards the frame.
// Frame statistics and configuration sit in a 32-byte register window.
module eth_rx_filter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_tdata,
    input  logic [3:0]  s_tkeep,
    input  logic        s_tlast,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] m_tdata,
    output logic [3:0]  m_tkeep,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic        wdone,
    input  logic [31:0] raddr,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        rdone
);

    // state  | meaning
    // HDR    | collecting header beats 0..3, decide at beat 3
    // REPLAY | presenting the four buffered beats downstream
    // BODY   | combinational pass-through until tlast
    // DROP   | swallowing the rest of a rejected frame
    typedef enum logic [1:0] {HDR, REPLAY, BODY, DROP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic [1:0]  rep_idx_q, rep_idx_d;
    logic [31:0] buf_data_q [4];
    logic [3:0]  buf_keep_q [4];
    logic        buf_last_q [4];
    logic        buf_we;

    logic [1:0]  ctrl_q;
    logic [15:0] etype_q;
    logic [31:0] rx_cnt_q, pass_cnt_q, drop_cnt_q, runt_cnt_q;
    logic        inc_rx, inc_pass, inc_drop, inc_runt;
    logic        clear;

    logic [31:0] woff, roff;
    logic        w_hit, r_hit;
    logic [31:0] rd_mux;
    logic        wdone_q, rdone_q;
    logic [31:0] rdata_q;

    logic [15:0] etype_rx;
    logic        pass;

    logic        unused_bits;
    assign unused_bits = &{1'b0, wdata[31:16]};

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Decision uses the live beat 3 and the CTRL/ETYPE values of that cycle.
    assign etype_rx = {s_tdata[7:0], s_tdata[15:8]};
    assign pass     = !ctrl_q[0] | ((etype_rx == etype_q) ^ ctrl_q[1]);

    // State, indices and header buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HDR;
            hdr_idx_q <= 2'd0;
            rep_idx_q <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                buf_data_q[i] <= 32'd0;
                buf_keep_q[i] <= 4'd0;
                buf_last_q[i] <= 1'b0;
            end
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            rep_idx_q <= rep_idx_d;
            if (buf_we) begin
                buf_data_q[hdr_idx_q] <= s_tdata;
                buf_keep_q[hdr_idx_q] <= s_tkeep;
                buf_last_q[hdr_idx_q] <= s_tlast;
            end
        end
    end

    // Next state, stream outputs and counter increment requests.
    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        rep_idx_d = rep_idx_q;
        buf_we    = 1'b0;
        s_tready  = 1'b0;
        m_tvalid  = 1'b0;
        m_tdata   = 32'd0;
        m_tkeep   = 4'd0;
        m_tlast   = 1'b0;
        inc_rx    = 1'b0;
        inc_pass  = 1'b0;
        inc_drop  = 1'b0;
        inc_runt  = 1'b0;
        case (state_q)
            HDR: begin
                s_tready = 1'b1;
                if (s_tvalid) begin
                    buf_we    = 1'b1;
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    if (hdr_idx_q != 2'd3) begin
                        if (s_tlast) begin
                            inc_rx    = 1'b1;
                            inc_runt  = 1'b1;
                            hdr_idx_d = 2'd0;
                        end
                    end else begin
                        hdr_idx_d = 2'd0;
                        if (s_tlast && (s_tkeep[1:0] != 2'b11)) begin
                            inc_rx   = 1'b1;
                            inc_runt = 1'b1;
                        end else if (pass) begin
                            state_d   = REPLAY;
                            rep_idx_d = 2'd0;
                        end else begin
                            inc_rx   = 1'b1;
                            inc_drop = 1'b1;
                            state_d  = s_tlast ? HDR : DROP;
                        end
                    end
                end
            end
            REPLAY: begin
                m_tvalid = 1'b1;
                m_tdata  = buf_data_q[rep_idx_q];
                m_tkeep  = buf_keep_q[rep_idx_q];
                m_tlast  = buf_last_q[rep_idx_q];
                if (m_tready) begin
                    rep_idx_d = rep_idx_q + 2'd1;
                    if (rep_idx_q == 2'd3) begin
                        if (buf_last_q[3]) begin
                            inc_rx   = 1'b1;
                            inc_pass = 1'b1;
                            state_d  = HDR;
                        end else begin
                            state_d = BODY;
                        end
                    end
                end
            end
            BODY: begin
                m_tvalid = s_tvalid;
                m_tdata  = s_tdata;
                m_tkeep  = s_tkeep;
                m_tlast  = s_tlast;
                s_tready = m_tready;
                if (s_tvalid && m_tready && s_tlast) begin
                    inc_rx   = 1'b1;
                    inc_pass = 1'b1;
                    state_d  = HDR;
                end
            end
            DROP: begin
                s_tready = 1'b1;
                if (s_tvalid && s_tlast) state_d = HDR;
            end
            default: state_d = HDR;
        endcase
    end

    // Window decode; the subtraction wraps so addresses below the base miss too.
    assign woff  = waddr - BASE_ADDR;
    assign roff  = raddr - BASE_ADDR;
    assign w_hit = (woff < 32'd32);
    assign r_hit = (roff < 32'd32);
    assign clear = we && w_hit && (woff[4:0] == 5'h18) && wdata[0];

    // Read data selection for in-window offsets.
    always_comb begin
        rd_mux = 32'd0;
        case (roff[4:0])
            5'h00:   rd_mux = {30'd0, ctrl_q};
            5'h04:   rd_mux = {16'd0, etype_q};
            5'h08:   rd_mux = rx_cnt_q;
            5'h0C:   rd_mux = pass_cnt_q;
            5'h10:   rd_mux = drop_cnt_q;
            5'h14:   rd_mux = runt_cnt_q;
            default: rd_mux = 32'd0;
        endcase
    end

    // Configuration writes and one-cycle bus responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= 2'd0;
            etype_q <= 16'h0800;
            wdone_q <= 1'b0;
            rdone_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            if (we && w_hit && (woff[4:0] == 5'h00)) ctrl_q  <= wdata[1:0];
            if (we && w_hit && (woff[4:0] == 5'h04)) etype_q <= wdata[15:0];
            wdone_q <= we && w_hit;
            rdone_q <= re && r_hit;
            rdata_q <= (re && r_hit) ? rd_mux : 32'd0;
        end
    end

    // Saturating frame counters; a clear in the same cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt_q   <= 32'd0;
            pass_cnt_q <= 32'd0;
            drop_cnt_q <= 32'd0;
            runt_cnt_q <= 32'd0;
        end else if (clear) begin
            rx_cnt_q   <= 32'd0;
            pass_cnt_q <= 32'd0;
            drop_cnt_q <= 32'd0;
            runt_cnt_q <= 32'd0;
        end else begin
            if (inc_rx)   rx_cnt_q   <= sat_inc(rx_cnt_q);
            if (inc_pass) pass_cnt_q <= sat_inc(pass_cnt_q);
            if (inc_drop) drop_cnt_q <= sat_inc(drop_cnt_q);
            if (inc_runt) runt_cnt_q <= sat_inc(runt_cnt_q);
        end
    end

    assign wdone = wdone_q;
    assign rdone = rdone_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_eth_rx_filter.sv
// Directed bench for eth_rx_filter: register access, pass/drop/runt frames,
// backpressure, counter clear and mid-frame reset.
module tb_eth_rx_filter;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_ETYP = BASE + 32'h04;
    localparam logic [31:0] A_RX   = BASE + 32'h08;
    localparam logic [31:0] A_PASS = BASE + 32'h0C;
    localparam logic [31:0] A_DROP = BASE + 32'h10;
    localparam logic [31:0] A_RUNT = BASE + 32'h14;
    localparam logic [31:0] A_CLR  = BASE + 32'h18;

    logic        clk, rst;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast, s_tvalid, s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast, m_tvalid, m_tready;
    logic [31:0] waddr, wdata, raddr, rdata;
    logic        we, wdone, re, rdone;

    eth_rx_filter #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .waddr(waddr), .wdata(wdata), .we(we), .wdone(wdone),
        .raddr(raddr), .re(re), .rdata(rdata), .rdone(rdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rise_cyc = -1;
    int          acc_cyc = -1;
    int          valid_cnt = 0;
    int          nrdy_cnt = 0;
    int          fid = 0;
    bit          tog = 1'b0;
    bit          prev_v = 1'b0;
    bit          prev_r = 1'b0;
    logic [37:0] prev_beat = '0;
    logic [36:0] got[$];
    logic [36:0] sent[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then advance to just after the rising edge.
    task automatic tick(output bit rdy);
        @(negedge clk);
        rdy = s_tready;
        if (!rst) begin
            if (m_tvalid && m_tready) got.push_back({m_tlast, m_tkeep, m_tdata});
            if (m_tvalid) valid_cnt++;
            if (!s_tready) nrdy_cnt++;
            if (m_tvalid && !prev_v) rise_cyc = cyc;
            if (prev_v && !prev_r)
                chk("stall_hold", {m_tvalid, m_tlast, m_tkeep, m_tdata}, prev_beat);
            prev_v    = m_tvalid;
            prev_r    = m_tready;
            prev_beat = {m_tvalid, m_tlast, m_tkeep, m_tdata};
        end
        @(posedge clk);
        #1;
        cyc++;
        m_tready = tog ? ~m_tready : 1'b1;
    endtask

    task automatic idle(input int n);
        bit r;
        repeat (n) tick(r);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bit r;
        we = 1'b1; waddr = a; wdata = d;
        tick(r);
        we = 1'b0;
        chk("wdone", wdone, 1'b1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic ok);
        bit r;
        re = 1'b1; raddr = a;
        tick(r);
        re = 1'b0;
        ok = rdone;
        d  = rdata;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        ok;
        rd(a, d, ok);
        chk({tag, "_rdone"}, ok, 1'b1);
        chk(tag, d, exp);
    endtask

    function automatic logic [36:0] mk_beat(input int f, input int i, input int n,
                                            input logic [15:0] et, input logic [3:0] k3);
        logic [15:0] lo;
        logic [3:0]  k;
        lo = (i == 3) ? {et[7:0], et[15:8]} : 16'hC000 + 16'(i);
        k  = (i == 3) ? k3 : ((i == n - 1) ? 4'b0111 : 4'hF);
        return {(i == n - 1), k, 8'(f), 8'(i), lo};
    endfunction

    // Drives one frame; stop >= 0 leaves that beat presented and returns.
    task automatic send(input int n, input logic [15:0] et, input logic [3:0] k3,
                        input bit gaps, input bit clr_last, input int stop, output int base);
        bit r;
        int guard;
        base = got.size();
        sent.delete();
        fid++;
        for (int i = 0; i < n; i++) begin
            logic [36:0] b;
            b = mk_beat(fid, i, n, et, k3);
            sent.push_back(b);
            if (gaps) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(0, 2)) tick(r);
            end
            {s_tlast, s_tkeep, s_tdata} = b;
            s_tvalid = 1'b1;
            if (i == stop) return;
            if (clr_last && i == n - 1) begin
                we = 1'b1; waddr = A_CLR; wdata = 32'd1;
            end
            guard = 0;
            do begin
                tick(r);
                we = 1'b0;
                guard++;
            end while (!r && guard < 200);
            if (!r) chk("accept_timeout", r, 1'b1);
            if (i == 3) acc_cyc = cyc;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input int base);
        chk({tag, "_nbeats"}, got.size() - base, sent.size());
        foreach (sent[i])
            if (base + i < got.size()) chk($sformatf("%s_beat%0d", tag, i), got[base + i], sent[i]);
    endtask

    initial begin
        logic [31:0] d;
        logic        ok;
        int          base, vbase, nbase;

        rst = 1'b1; s_tdata = '0; s_tkeep = '0; s_tlast = 0; s_tvalid = 0; m_tready = 1;
        waddr = '0; wdata = '0; we = 0; raddr = '0; re = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", s_tready, 1'b1);
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_m_tdata", m_tdata, 32'd0);
        chk("rst_rdone", rdone, 1'b0);
        chk("rst_wdone", wdone, 1'b0);
        rst = 1'b0;
        idle(2);

        // 1: reset values and bus timing
        chk_rd("ctrl_rst", A_CTRL, 32'd0);
        chk_rd("etype_rst", A_ETYP, 32'h0000_0800);
        chk_rd("rx_rst", A_RX, 32'd0);
        chk_rd("pass_rst", A_PASS, 32'd0);
        chk_rd("drop_rst", A_DROP, 32'd0);
        chk_rd("runt_rst", A_RUNT, 32'd0);
        chk_rd("clear_read", A_CLR, 32'd0);
        chk_rd("unmapped_read", BASE + 32'h1C, 32'd0);
        idle(1);
        chk("rdone_one_cycle", rdone, 1'b0);
        rd(BASE + 32'h20, d, ok);
        chk("oow_high_rdone", ok, 1'b0);
        rd(BASE - 32'h4, d, ok);
        chk("oow_low_rdone", ok, 1'b0);

        // 2: matching frame passes intact with one-cycle latency
        wr(A_CTRL, 32'd1);
        send(16, 16'h0800, 4'hF, 1'b0, 1'b0, -1, base);
        idle(4);
        chk_frame("pass16", base);
        chk("latency", rise_cyc, acc_cyc);
        chk_rd("pass16_rx", A_RX, 32'd1);
        chk_rd("pass16_pass", A_PASS, 32'd1);
        chk_rd("pass16_drop", A_DROP, 32'd0);

        // 3: non-matching frame dropped, then passed with INVERT
        wr(A_CLR, 32'd1);
        vbase = valid_cnt; nbase = nrdy_cnt;
        send(10, 16'h0806, 4'hF, 1'b0, 1'b0, -1, base);
        idle(4);
        chk("drop_no_valid", valid_cnt - vbase, 0);
        chk("drop_s_tready", nrdy_cnt - nbase, 0);
        chk("drop_no_beats", got.size() - base, 0);
        chk_rd("drop_cnt", A_DROP, 32'd1);
        chk_rd("drop_rx", A_RX, 32'd1);
        wr(A_CTRL, 32'd3);
        wr(A_CLR, 32'd1);
        send(10, 16'h0806, 4'hF, 1'b0, 1'b0, -1, base);
        idle(4);
        chk_frame("invert", base);
        chk_rd("invert_pass", A_PASS, 32'd1);
        chk_rd("invert_drop", A_DROP, 32'd0);

        // 4: runts
        wr(A_CTRL, 32'd1);
        wr(A_CLR, 32'd1);
        send(3, 16'h0800, 4'hF, 1'b0, 1'b0, -1, base);
        send(4, 16'h0800, 4'b0001, 1'b0, 1'b0, -1, nbase);
        idle(6);
        chk("runt_no_beats", got.size() - base, 0);
        chk_rd("runt_cnt", A_RUNT, 32'd2);
        chk_rd("runt_rx", A_RX, 32'd2);
        chk_rd("runt_pass", A_PASS, 32'd0);

        // 5: backpressure and gapped input
        wr(A_CLR, 32'd1);
        tog = 1'b1;
        send(20, 16'h0800, 4'hF, 1'b1, 1'b0, -1, base);
        idle(8);
        tog = 1'b0;
        idle(1);
        chk_frame("stall20", base);
        chk_rd("stall20_pass", A_PASS, 32'd1);

        // 6: clear coinciding with a passing tlast, then reset mid-BODY
        wr(A_CLR, 32'd1);
        send(6, 16'h0800, 4'hF, 1'b0, 1'b1, -1, base);
        idle(2);
        chk_frame("clrlast", base);
        chk_rd("clrlast_pass", A_PASS, 32'd0);
        chk_rd("clrlast_rx", A_RX, 32'd0);
        send(4, 16'h0800, 4'hF, 1'b0, 1'b0, -1, base);
        idle(6);
        chk_frame("short4", base);
        chk_rd("short4_pass", A_PASS, 32'd1);
        send(10, 16'h0800, 4'hF, 1'b0, 1'b0, 6, base);
        #1;
        chk("body_m_tvalid", m_tvalid, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_m_tvalid", m_tvalid, 1'b0);
        chk("midrst_s_tready", s_tready, 1'b1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_v = 1'b0;
        idle(1);
        chk_rd("midrst_rx", A_RX, 32'd0);
        chk_rd("midrst_pass", A_PASS, 32'd0);
        chk_rd("midrst_ctrl", A_CTRL, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
